// File: rtl/inst_fetch_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer. The state encoding
// and byte-count constants are also consumed by the IF-stage stall logic, so
// keep them stable.
package inst_fetch_seq_pkg;

  localparam int BYTES_PER_INST = 4;
  localparam int CNT_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2
  } fsm_state_e;

  // True when cnt addresses the most significant byte of the word.
  function automatic logic is_last_byte(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(BYTES_PER_INST - 1);
  endfunction

endpackage

// File: rtl/inst_fetch_seq_packer.sv
// inst_byte_packer: gathers bytes into a shadow word, one lane per write,
// and commits the whole word to word_o only when the last lane arrives, so
// the visible instruction never shows a partially assembled word.
//  clk, rst  : clock, synchronous active-high reset
//  wr_en_i   : write byte_i into lane cnt_i this cycle
//  cnt_i     : byte lane (0 = least significant, little-endian)
//  byte_i    : incoming memory byte
//  word_o    : last fully assembled instruction (0 after reset)
module inst_byte_packer
  import inst_fetch_seq_pkg::*;
#(
  parameter int MCS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [CNT_W-1:0]          cnt_i,
  input  logic [MCS-1:0]            byte_i,
  output logic [BYTES_PER_INST*MCS-1:0] word_o
);

  logic [BYTES_PER_INST-1:0][MCS-1:0] shadow_q, shadow_d;
  logic [BYTES_PER_INST*MCS-1:0]      word_q;

  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[cnt_i] = byte_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      word_q   <= '0;
    end else if (wr_en_i) begin
      shadow_q <= shadow_d;
      // Commit includes the byte arriving this cycle.
      if (is_last_byte(cnt_i)) word_q <= shadow_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: sequences one byte-wide port of the instruction memory.
// Fetch reads 4 consecutive bytes (wrapping mod MEM_SIZE) into a 32-bit
// little-endian instruction; the loader writes single bytes and wins ties.
//  clk, rst                 : clock, synchronous active-high reset
//  fetch_req/addr/ready     : IF-stage request handshake
//  inst_valid, instruction  : 1-cycle completion pulse, held word
//  load_req/addr/data, ack  : loader byte write, ack pulses during the write
//  mem_addr/wr_en/wr_data   : memory array port (all 0 while idle)
//  mem_rd_data              : combinational read data for mem_addr
module inst_fetch_seq
  import inst_fetch_seq_pkg::*;
#(
  parameter int ADDR_SIZE     = 32,
  parameter int MEM_SIZE      = 1024,
  parameter int MEM_CELL_SIZE = 8,
  localparam int AW           = $clog2(MEM_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_req,
  input  logic [ADDR_SIZE-1:0]          fetch_addr,
  output logic                          fetch_ready,
  output logic                          inst_valid,
  output logic [4*MEM_CELL_SIZE-1:0]    instruction,
  input  logic                          load_req,
  input  logic [ADDR_SIZE-1:0]          load_addr,
  input  logic [MEM_CELL_SIZE-1:0]      load_data,
  output logic                          load_ack,
  output logic [AW-1:0]                 mem_addr,
  output logic                          mem_wr_en,
  output logic [MEM_CELL_SIZE-1:0]      mem_wr_data,
  input  logic [MEM_CELL_SIZE-1:0]      mem_rd_data
);

  fsm_state_e               state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [AW-1:0]            base_q;
  logic [AW-1:0]            laddr_q;
  logic [MEM_CELL_SIZE-1:0] ldata_q;
  logic                     inst_valid_q;

  // Only the low AW address bits select a memory cell.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[ADDR_SIZE-1:AW], load_addr[ADDR_SIZE-1:AW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      laddr_q      <= '0;
      ldata_q      <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            laddr_q <= load_addr[AW-1:0];
            ldata_q <= load_data;
            state_q <= ST_LOAD;
          end else if (fetch_req) begin
            base_q  <= fetch_addr[AW-1:0];
            cnt_q   <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_last_byte(cnt_q)) begin
            state_q      <= ST_IDLE;
            inst_valid_q <= 1'b1;
          end
        end
        ST_LOAD:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory port is a pure decode of the state so read data returns in the
  // same cycle the address is presented.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      ST_FETCH: mem_addr = base_q + AW'(cnt_q);  // carry dropped: wraps mod MEM_SIZE
      ST_LOAD: begin
        mem_addr    = laddr_q;
        mem_wr_en   = 1'b1;
        mem_wr_data = ldata_q;
      end
      default: ;
    endcase
  end

  assign fetch_ready = (state_q == ST_IDLE) && !load_req;
  assign load_ack    = (state_q == ST_LOAD);
  assign inst_valid  = inst_valid_q;

  inst_byte_packer #(.MCS(MEM_CELL_SIZE)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (state_q == ST_FETCH),
    .cnt_i   (cnt_q),
    .byte_i  (mem_rd_data),
    .word_o  (instruction)
  );

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Randomized bench for inst_fetch_seq. A request-level reference model decides
// when each request is accepted (port free + loader priority), computes the
// expected word from its own memory image and queues the expected response
// with its due cycle; a negedge monitor compares everything the DUT presents.
module tb_inst_fetch_seq;
  localparam int MS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0, load_req = 1'b0;
  logic [31:0] fetch_addr = '0, load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        fetch_ready, inst_valid, load_ack, mem_wr_en;
  logic [31:0] instruction;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wr_data, mem_rd_data;

  inst_fetch_seq dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .inst_valid(inst_valid), .instruction(instruction),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Physical memory array driven by the DUT port.
  logic [7:0] mem [MS];
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  // Reference memory image, updated when the model accepts a load.
  logic [7:0] ref_mem [MS];

  typedef struct { int due; logic [31:0] word; } fexp_t;
  typedef struct { int due; logic [9:0] a; logic [7:0] d; } lexp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } lreq_t;

  fexp_t       fq_exp[$];
  lexp_t       lq_exp[$];
  logic [31:0] fq_in[$];
  lreq_t       lq_in[$];

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int free_at = 0;
  logic acc_f = 1'b0, acc_l = 1'b0;
  logic fetch_live = 1'b0;
  int fst = 0;
  logic [9:0] fbase = '0;
  logic [31:0] last_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor + reference model.
  always @(negedge clk) begin
    logic idle, exp_iv, exp_ack;
    logic [31:0] w;
    logic [9:0] b;
    idle = (cyc >= free_at);
    if (cyc >= 1) begin
      chk("fetch_ready", 32'(fetch_ready), 32'(idle && !load_req));
      exp_iv = (fq_exp.size() > 0) && (fq_exp[0].due == cyc);
      chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
      if (exp_iv) last_word = fq_exp.pop_front().word;
      chk("instruction", instruction, last_word);
      exp_ack = (lq_exp.size() > 0) && (lq_exp[0].due == cyc);
      chk("load_ack", 32'(load_ack), 32'(exp_ack));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_ack));
      if (exp_ack) begin
        chk("load_mem_addr", 32'(mem_addr), 32'(lq_exp[0].a));
        chk("load_wr_data", 32'(mem_wr_data), 32'(lq_exp[0].d));
        void'(lq_exp.pop_front());
      end else if (fetch_live && cyc > fst && cyc <= fst + 4) begin
        chk("fetch_mem_addr", 32'(mem_addr), 32'((int'(fbase) + cyc - fst - 1) % MS));
      end else if (idle) begin
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        chk("idle_wr_data", 32'(mem_wr_data), 32'd0);
      end
    end
    acc_f = 1'b0;
    acc_l = 1'b0;
    if (rst) begin
      fq_exp.delete();
      lq_exp.delete();
      free_at    = cyc + 1;
      fetch_live = 1'b0;
      last_word  = '0;
    end else if (idle) begin
      if (load_req) begin
        acc_l = 1'b1;
        ref_mem[load_addr[9:0]] = load_data;
        lq_exp.push_back('{cyc + 1, load_addr[9:0], load_data});
        free_at = cyc + 2;
      end else if (fetch_req) begin
        acc_f = 1'b1;
        b = fetch_addr[9:0];
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = ref_mem[(int'(b) + k) % MS];
        fq_exp.push_back('{cyc + 5, w});
        free_at    = cyc + 5;
        fetch_live = 1'b1;
        fst        = cyc;
        fbase      = b;
      end
    end
  end

  // Driver: requests are held until the model says they were accepted.
  task automatic apply();
    fetch_req  = fq_in.size() > 0;
    fetch_addr = (fq_in.size() > 0) ? fq_in[0] : $urandom;
    load_req   = lq_in.size() > 0;
    if (lq_in.size() > 0) begin
      load_addr = lq_in[0].a;
      load_data = lq_in[0].d;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (acc_f) void'(fq_in.pop_front());
      if (acc_l) void'(lq_in.pop_front());
      apply();
    end
  endtask

  task automatic req_fetch(input logic [31:0] a);
    fq_in.push_back(a); apply();
  endtask

  task automatic req_load(input logic [31:0] a, input logic [7:0] d);
    lq_in.push_back('{a, d}); apply();
  endtask

  initial begin
    for (int i = 0; i < MS; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    ref_mem[0] = 8'h20; ref_mem[1] = 8'h08; ref_mem[2] = 8'h00; ref_mem[3] = 8'h05;

    run(3);
    rst = 1'b0;
    // Known word at address 0.
    req_fetch(32'd0);
    run(8);
    // Wrap past the top of memory.
    req_fetch(32'd1022);
    run(8);
    // Simultaneous load and fetch: load wins, fetch sees the new byte.
    req_load(32'd4, 8'hAB);
    req_fetch(32'd4);
    run(10);
    // Load raised mid-fetch is held off until the word completes.
    req_fetch(32'd8);
    run(2);
    req_load(32'd9, 8'h5A);
    run(10);
    // Reset in the third fetch cycle aborts the fetch.
    req_fetch(32'd12);
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(8);
    // Back-to-back fetches with fetch_req held.
    req_fetch(32'd0); req_fetch(32'd4); req_fetch(32'd8);
    run(20);
    // Random mix, upper address bits random.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) != 0) req_fetch($urandom);
      else req_load($urandom, 8'($urandom));
      if ($urandom_range(0, 3) == 0) req_fetch(32'd1020 + 32'($urandom_range(0, 3)));
      run($urandom_range(0, 6));
    end
    begin
      int t = 0;
      while ((fq_in.size() + lq_in.size() + fq_exp.size() + lq_exp.size()) != 0 && t < 3000) begin
        run(1);
        t++;
      end
      run(2);
      nvec++;
      if ((fq_in.size() + lq_in.size() + fq_exp.size() + lq_exp.size()) != 0) begin
        nerr++;
        $display("FAIL drain_timeout pending=%0d exp=0",
                 fq_in.size() + lq_in.size() + fq_exp.size() + lq_exp.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
